// File: rtl/calc_operand_regs_pkg.sv
// Shared types and constants for the calculator operand register slice.
// Optional backspace support is selected with CALC_BACKSPACE_EN.
package calc_pkg;

  localparam int HEX_W = 4;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [2:0] {
    ENTER1,
    OPSEL,
    ENTER2,
    BUSY,
    RESULT
  } state_t;

  function automatic int cnt_w(input int digits);
    return $clog2(digits + 1);
  endfunction

endpackage

// File: rtl/calc_operand_regs_if.sv
// Keypad, arithmetic-unit and display bundle for calc_operand_regs.
// The del pulse exists only when CALC_BACKSPACE_EN is defined.
interface calc_operand_regs_if #(
  parameter int DIGITS = 4,
  parameter int OPW    = 2
);
  localparam int W = 4 * DIGITS;

  logic           newhex;
  logic [3:0]     hexcode;
  logic           newop;
  logic [OPW-1:0] opcode;
  logic           eq;
`ifdef CALC_BACKSPACE_EN
  logic           del;
`endif
  logic [W-1:0]   ans;
  logic           ans_valid;
  logic [W-1:0]   V1_reg;
  logic [W-1:0]   V2_reg;
  logic [OPW-1:0] op_reg;
  logic           calc_req;
  logic           disp_sel;
  logic           busy;

  modport master (
    output newhex, hexcode, newop, opcode, eq,
`ifdef CALC_BACKSPACE_EN
    output del,
`endif
    output ans, ans_valid,
    input  V1_reg, V2_reg, op_reg,
    input  calc_req, disp_sel, busy
  );

  modport slave (
    input  newhex, hexcode, newop, opcode, eq,
`ifdef CALC_BACKSPACE_EN
    input  del,
`endif
    input  ans, ans_valid,
    output V1_reg, V2_reg, op_reg,
    output calc_req, disp_sel, busy
  );

endinterface

// File: rtl/calc_operand_regs_digit_reg.sv
// One operand register with its digit count; saturates at DIGITS digits.
// Backspace input present only when CALC_BACKSPACE_EN is defined.
import calc_pkg::*;

module calc_digit_reg #(
  parameter int DIGITS = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load,
  input  logic                      shift_in,
  input  logic                      clear,
  input  logic                      set_full,
`ifdef CALC_BACKSPACE_EN
  input  logic                      bksp,
`endif
  input  logic [HEX_W-1:0]          hex,
  input  logic [HEX_W*DIGITS-1:0]   full_val,
  output logic [HEX_W*DIGITS-1:0]   value
);

  localparam int W  = HEX_W * DIGITS;
  localparam int CW = cnt_w(DIGITS);
  localparam logic [CW-1:0] FULL = CW'(DIGITS);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value <= '0;
      count <= '0;
    end else if (clear) begin
      value <= '0;
      count <= '0;
    end else if (set_full) begin
      value <= full_val;
      count <= FULL;
    end else if (load) begin
      value <= W'(hex);
      count <= ONE;
    end else if (shift_in) begin
      if (count == '0) begin
        value <= W'(hex);
        count <= ONE;
      end else if (count != FULL) begin
        value <= (value << HEX_W) | W'(hex);
        count <= count + ONE;
      end
`ifdef CALC_BACKSPACE_EN
    end else if (bksp && count != '0) begin
      value <= value >> HEX_W;
      count <= count - ONE;
`endif
    end
  end

endmodule

// File: rtl/calc_operand_regs.sv
// Operand/operator registers and arithmetic handshake for the calculator.
// Build with CALC_BACKSPACE_EN to add the del (backspace) key.
import calc_pkg::*;

module calc_operand_regs #(
  parameter int DIGITS = 4,
  parameter int OPW    = 2
) (
  input logic          clock,
  input logic          reset,
  calc_operand_regs_if.slave bus
);

  state_t         state;
  state_t         after_st;
  logic [OPW-1:0] op_q;
  logic [OPW-1:0] pend_op;
  logic           req_q;
  logic           busy_q;
  logic           dsel_q;

  logic k_eq, k_op, k_hex;
  logic v1_load, v1_shift, v1_full;
  logic v2_load, v2_shift, v2_full, v2_clr;

  assign k_eq  = bus.eq;
  assign k_op  = bus.newop & ~bus.eq;
  assign k_hex = bus.newhex & ~bus.newop & ~bus.eq;

`ifdef CALC_BACKSPACE_EN
  logic k_del, v1_bksp, v2_bksp;
  assign k_del = bus.del & ~bus.newhex
               & ~bus.newop & ~bus.eq;
`endif

  always_comb begin
    v1_load  = 1'b0;
    v1_shift = 1'b0;
    v1_full  = 1'b0;
    v2_load  = 1'b0;
    v2_shift = 1'b0;
    v2_full  = 1'b0;
    v2_clr   = 1'b0;
`ifdef CALC_BACKSPACE_EN
    v1_bksp  = 1'b0;
    v2_bksp  = 1'b0;
`endif
    case (state)
      ENTER1: begin
        v1_shift = k_hex;
        v2_clr   = k_op;
`ifdef CALC_BACKSPACE_EN
        v1_bksp  = k_del;
`endif
      end
      OPSEL: begin
        v2_load = k_hex;
        v2_full = k_eq;
      end
      ENTER2: begin
        v2_shift = k_hex;
`ifdef CALC_BACKSPACE_EN
        v2_bksp  = k_del;
`endif
      end
      BUSY: begin
        v1_full = bus.ans_valid;
        v2_clr  = bus.ans_valid && after_st == OPSEL;
      end
      RESULT: begin
        v1_load = k_hex;
        v2_clr  = k_op;
      end
      default: ;
    endcase
  end

  // Keys are one-hot after priority masking, so each state decodes a winner.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ENTER1;
      after_st <= ENTER1;
      op_q     <= '0;
      pend_op  <= '0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      dsel_q   <= 1'b0;
    end else begin
      case (state)
        ENTER1: begin
          if (k_op) begin
            op_q  <= bus.opcode;
            state <= OPSEL;
          end
        end
        OPSEL: begin
          unique case (1'b1)
            k_eq: begin
              after_st <= RESULT;
              state    <= BUSY;
              req_q    <= 1'b1;
              busy_q   <= 1'b1;
            end
            k_op: op_q <= bus.opcode;
            k_hex: begin
              state  <= ENTER2;
              dsel_q <= 1'b1;
            end
            default: ;
          endcase
        end
        ENTER2: begin
          unique case (1'b1)
            k_eq: begin
              after_st <= RESULT;
              state    <= BUSY;
              req_q    <= 1'b1;
              busy_q   <= 1'b1;
              dsel_q   <= 1'b0;
            end
            k_op: begin
              pend_op  <= bus.opcode;
              after_st <= OPSEL;
              state    <= BUSY;
              req_q    <= 1'b1;
              busy_q   <= 1'b1;
              dsel_q   <= 1'b0;
            end
            default: ;
          endcase
        end
        BUSY: begin
          if (bus.ans_valid) begin
            state  <= after_st;
            req_q  <= 1'b0;
            busy_q <= 1'b0;
            if (after_st == OPSEL)
              op_q <= pend_op;
          end
        end
        RESULT: begin
          unique case (1'b1)
            k_eq: begin
              after_st <= RESULT;
              state    <= BUSY;
              req_q    <= 1'b1;
              busy_q   <= 1'b1;
            end
            k_op: begin
              op_q  <= bus.opcode;
              state <= OPSEL;
            end
            k_hex: state <= ENTER1;
            default: ;
          endcase
        end
        default: state <= ENTER1;
      endcase
    end
  end

  assign bus.op_reg   = op_q;
  assign bus.calc_req = req_q;
  assign bus.busy     = busy_q;
  assign bus.disp_sel = dsel_q;

  calc_digit_reg #(.DIGITS(DIGITS)) u_v1 (
    .clock    (clock),
    .reset    (reset),
    .load     (v1_load),
    .shift_in (v1_shift),
    .clear    (1'b0),
    .set_full (v1_full),
`ifdef CALC_BACKSPACE_EN
    .bksp     (v1_bksp),
`endif
    .hex      (bus.hexcode),
    .full_val (bus.ans),
    .value    (bus.V1_reg)
  );

  // V2 takes V1 wholesale when equals follows an operator directly.
  calc_digit_reg #(.DIGITS(DIGITS)) u_v2 (
    .clock    (clock),
    .reset    (reset),
    .load     (v2_load),
    .shift_in (v2_shift),
    .clear    (v2_clr),
    .set_full (v2_full),
`ifdef CALC_BACKSPACE_EN
    .bksp     (v2_bksp),
`endif
    .hex      (bus.hexcode),
    .full_val (bus.V1_reg),
    .value    (bus.V2_reg)
  );

endmodule

// File: tb/tb_calc_operand_regs.sv
// Directed scoreboard bench for calc_operand_regs (DIGITS=4, OPW=2).
// Backspace steps run only when CALC_BACKSPACE_EN is defined.
import calc_pkg::*;

module tb_calc_operand_regs;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  calc_operand_regs_if #(.DIGITS(4), .OPW(2)) bus ();

  calc_operand_regs #(.DIGITS(4), .OPW(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic expect_v(input string t, input logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic observe(input logic [31:0] o);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard_empty got %h", o);
    end else begin
      e = sb.pop_front();
      assert (o === e.v) passed++;
      else $error("FAIL %s: got %h want %h", e.tag, o, e.v);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic key(input logic [3:0] h);
    bus.newhex  = 1'b1;
    bus.hexcode = h;
    step();
    bus.newhex  = 1'b0;
  endtask

  task automatic opk(input logic [1:0] o);
    bus.newop  = 1'b1;
    bus.opcode = o;
    step();
    bus.newop  = 1'b0;
  endtask

  task automatic eqk();
    bus.eq = 1'b1;
    step();
    bus.eq = 1'b0;
  endtask

  task automatic answer(input logic [15:0] a);
    bus.ans       = a;
    bus.ans_valid = 1'b1;
    step();
    bus.ans_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  function automatic logic [31:0] st(input state_t s);
    return 32'(s);
  endfunction

  initial begin
    bus.newhex    = 1'b0;
    bus.hexcode   = 4'h0;
    bus.newop     = 1'b0;
    bus.opcode    = 2'd0;
    bus.eq        = 1'b0;
    bus.ans       = 16'h0;
    bus.ans_valid = 1'b0;
`ifdef CALC_BACKSPACE_EN
    bus.del       = 1'b0;
`endif
    step();
    step();

    expect_v("rst_v1", 0);
    expect_v("rst_v2", 0);
    expect_v("rst_op", 0);
    expect_v("rst_req", 0);
    expect_v("rst_busy", 0);
    expect_v("rst_dsel", 0);
    expect_v("rst_state", st(ENTER1));
    observe(32'(bus.V1_reg));
    observe(32'(bus.V2_reg));
    observe(32'(bus.op_reg));
    observe(32'(bus.calc_req));
    observe(32'(bus.busy));
    observe(32'(bus.disp_sel));
    observe(st(dut.state));
    reset = 1'b1;

    // digit entry saturates after four digits
    key(4'h1);
    expect_v("first_digit", 16'h0001);
    observe(32'(bus.V1_reg));
    key(4'h2);
    key(4'h3);
    key(4'h4);
    key(4'h5);
    expect_v("sat_v1", 16'h1234);
    expect_v("sat_state", st(ENTER1));
    expect_v("sat_dsel", 0);
    observe(32'(bus.V1_reg));
    observe(st(dut.state));
    observe(32'(bus.disp_sel));

    // basic add with a slow arithmetic unit
    pulse_reset();
    key(4'h1);
    key(4'h2);
    opk(OP_ADD);
    expect_v("opsel_state", st(OPSEL));
    expect_v("opsel_v2", 0);
    observe(st(dut.state));
    observe(32'(bus.V2_reg));
    key(4'h3);
    expect_v("e2_dsel", 1);
    expect_v("e2_v2", 16'h0003);
    expect_v("e2_state", st(ENTER2));
    observe(32'(bus.disp_sel));
    observe(32'(bus.V2_reg));
    observe(st(dut.state));
    eqk();
    for (int i = 0; i < 3; i++) begin
      expect_v($sformatf("hold_busy%0d", i), 1);
      expect_v($sformatf("hold_req%0d", i), 1);
      expect_v($sformatf("hold_dsel%0d", i), 0);
      observe(32'(bus.busy));
      observe(32'(bus.calc_req));
      observe(32'(bus.disp_sel));
      if (i == 1) begin
        bus.newhex  = 1'b1;
        bus.hexcode = 4'h9;
      end
      step();
      bus.newhex = 1'b0;
    end
    expect_v("busy_key_v1", 16'h0012);
    expect_v("busy_key_v2", 16'h0003);
    observe(32'(bus.V1_reg));
    observe(32'(bus.V2_reg));
    answer(16'h0015);
    expect_v("ans_v1", 16'h0015);
    expect_v("ans_req", 0);
    expect_v("ans_busy", 0);
    expect_v("ans_state", st(RESULT));
    observe(32'(bus.V1_reg));
    observe(32'(bus.calc_req));
    observe(32'(bus.busy));
    observe(st(dut.state));

    // stray ans_valid outside BUSY
    answer(16'hffff);
    expect_v("stray_ans_v1", 16'h0015);
    expect_v("stray_ans_state", st(RESULT));
    observe(32'(bus.V1_reg));
    observe(st(dut.state));

    // repeated equals keeps V2
    eqk();
    expect_v("rep_req", 1);
    expect_v("rep_v2", 16'h0003);
    observe(32'(bus.calc_req));
    observe(32'(bus.V2_reg));
    answer(16'h0018);
    expect_v("rep_v1", 16'h0018);
    expect_v("rep_state", st(RESULT));
    observe(32'(bus.V1_reg));
    observe(st(dut.state));
    key(4'h7);
    expect_v("flow_v1", 16'h0007);
    expect_v("flow_state", st(ENTER1));
    observe(32'(bus.V1_reg));
    observe(st(dut.state));

    // chained operation
    pulse_reset();
    key(4'h2);
    opk(OP_ADD);
    key(4'h3);
    opk(OP_MUL);
    expect_v("chain_busy_state", st(BUSY));
    expect_v("chain_busy_op", 32'(OP_ADD));
    observe(st(dut.state));
    observe(32'(bus.op_reg));
    answer(16'h0005);
    expect_v("chain_v1", 16'h0005);
    expect_v("chain_op", 32'(OP_MUL));
    expect_v("chain_v2", 0);
    expect_v("chain_state", st(OPSEL));
    expect_v("chain_req", 0);
    observe(32'(bus.V1_reg));
    observe(32'(bus.op_reg));
    observe(32'(bus.V2_reg));
    observe(st(dut.state));
    observe(32'(bus.calc_req));

    // coincident keys: equals wins
    key(4'h4);
    bus.newhex  = 1'b1;
    bus.hexcode = 4'h6;
    bus.newop   = 1'b1;
    bus.opcode  = OP_SUB;
    bus.eq      = 1'b1;
    step();
    bus.newhex = 1'b0;
    bus.newop  = 1'b0;
    bus.eq     = 1'b0;
    expect_v("prio_state", st(BUSY));
    expect_v("prio_v2", 16'h0004);
    expect_v("prio_op", 32'(OP_MUL));
    observe(st(dut.state));
    observe(32'(bus.V2_reg));
    observe(32'(bus.op_reg));
    answer(16'h0009);
    expect_v("prio_v1", 16'h0009);
    observe(32'(bus.V1_reg));

    // equals straight after operator copies V1 into V2
    opk(OP_SUB);
    eqk();
    expect_v("copy_v2", 16'h0009);
    expect_v("copy_state", st(BUSY));
    observe(32'(bus.V2_reg));
    observe(st(dut.state));
    answer(16'h0000);
    eqk();
    expect_v("pre_abort_req", 1);
    observe(32'(bus.calc_req));

    // asynchronous abort while waiting for the answer
    reset = 1'b0;
    #1;
    expect_v("abort_req", 0);
    expect_v("abort_busy", 0);
    expect_v("abort_v1", 0);
    expect_v("abort_v2", 0);
    expect_v("abort_op", 0);
    expect_v("abort_dsel", 0);
    expect_v("abort_state", st(ENTER1));
    observe(32'(bus.calc_req));
    observe(32'(bus.busy));
    observe(32'(bus.V1_reg));
    observe(32'(bus.V2_reg));
    observe(32'(bus.op_reg));
    observe(32'(bus.disp_sel));
    observe(st(dut.state));
    step();
    reset = 1'b1;

`ifdef CALC_BACKSPACE_EN
    key(4'h1);
    key(4'h2);
    key(4'h3);
    bus.del = 1'b1;
    step();
    bus.del = 1'b0;
    expect_v("del_v1", 16'h0012);
    observe(32'(bus.V1_reg));
    for (int i = 0; i < 3; i++) begin
      bus.del = 1'b1;
      step();
      bus.del = 1'b0;
    end
    expect_v("del_empty_v1", 0);
    observe(32'(bus.V1_reg));
    key(4'h5);
    expect_v("del_reload_v1", 16'h0005);
    observe(32'(bus.V1_reg));
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/calc_operand_regs.md
Name: calc_operand_regs

Overview:
- Parametrised successor to the calculator operand register block.
- Collects keypad hex digits into two operands (V1, V2) and latches the operator.
- Runs a request/acknowledge handshake with the arithmetic unit, loads the result back into V1, and supports chained and repeated operations.
- Sits between the keypad decoder and the arithmetic/display blocks.

Parameters:
- DIGITS, 4: max hex digits per operand; operand width W = 4*DIGITS.
- OPW, 2: opcode width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- newhex  in  1  one-cycle pulse: hex key pressed.
- hexcode  in  4  digit for newhex.
- newop  in  1  one-cycle pulse: operator key pressed.
- opcode  in  OPW  operator for newop.
- eq  in  1  one-cycle pulse: equals pressed.
- ans  in  W  arithmetic result.
- ans_valid  in  1  ans valid; acknowledges calc_req.
- V1_reg  out  W  operand 1 / result.
- V2_reg  out  W  operand 2.
- op_reg  out  OPW  latched operator.
- calc_req  out  1  request to arithmetic unit.
- disp_sel  out  1  0 = display V1, 1 = display V2.
- busy  out  1  high while awaiting ans.

Behaviour:
- Reset (reset=0, asynchronous): state ENTER1; V1, V2, op_reg, both digit counts, pend_op, after_st, calc_req, busy, disp_sel all 0. All outputs are registered.
- Key priority when pulses coincide: eq > newop > newhex. Only the winner acts.
- Digit entry into the active register, with count c (width $clog2(DIGITS+1)):
  - c==0: reg = zero-extended hexcode, c=1.
  - 0<c<DIGITS: reg = {reg[W-5:0], hexcode}, c++.
  - c==DIGITS: digit ignored; reg and c unchanged (saturate, no shift-out).
- ENTER1:
  - newhex: digit into V1.
  - newop: op_reg=opcode, V2=0, c2=0, go to OPSEL.
  - eq: no effect.
- OPSEL:
  - newop: op_reg replaced.
  - newhex: V2=hexcode, c2=1, go to ENTER2.
  - eq: V2=V1, after_st=RESULT, go to BUSY.
- ENTER2:
  - newhex: digit into V2.
  - eq: after_st=RESULT, go to BUSY.
  - newop: pend_op=opcode, after_st=OPSEL, go to BUSY (chained operation).
- BUSY:
  - calc_req=1 and busy=1 from the first cycle in BUSY; all key pulses are dropped.
  - On ans_valid: V1=ans, c1=DIGITS, calc_req and busy fall next cycle, go to after_st.
  - If after_st==OPSEL: op_reg=pend_op, V2=0, c2=0.
- RESULT:
  - newhex: V1=hexcode, c1=1, go to ENTER1 (flow-mode overwrite).
  - newop: op_reg=opcode, V2=0, c2=0, go to OPSEL (result becomes V1).
  - eq: repeat the last operation with V2 unchanged; after_st=RESULT, go to BUSY.
- ans_valid outside BUSY: ignored.
- ans is taken as W bits; any overflow handling is the arithmetic unit's responsibility.
- disp_sel=1 only in ENTER2, otherwise 0.
- Reset asserted mid-BUSY: abort immediately; calc_req drops asynchronously.
- Minimum latency: key pulse at edge n, register/state updated at edge n+1.

Optional Feature:
- Macro: CALC_BACKSPACE_EN.
- Defined:
  - Adds input port del (1 bit, one-cycle pulse), lowest priority.
  - In ENTER1 or ENTER2, del shifts the active register right 4 bits (zero fill) and decrements c.
  - At c==0, del does nothing.
  - In OPSEL, RESULT and BUSY, del is ignored.
- Undefined: port del absent; logic not built.

Decomposition:
- Package calc_pkg holds:
  - state typedef {ENTER1, OPSEL, ENTER2, BUSY, RESULT};
  - opcode constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3;
  - HEX_W=4.
- Sub-module calc_digit_reg (parameter DIGITS) holds one operand and its count, with ports: load, shift-in, clear, set-full, optional backspace. Instanced twice (V1, V2).
- Top level keeps the FSM, op_reg, pend_op and the handshake.

Test Plan:
- Digit entry and saturation: reset, keys 1,2,3,4,5 -> V1_reg=16'h1234, 5 ignored, state ENTER1, disp_sel=0.
- Basic operation and handshake: keys 1,2, op=OP_ADD, key 3, eq, hold ans_valid low 3 cycles -> busy=1 and calc_req=1 held for 3 cycles, V2_reg=16'h0003. Then ans=16'h0015 with ans_valid -> V1_reg=16'h0015 next edge, calc_req=0, state RESULT.
- Chaining: V1=16'h0002, OP_ADD, V2=16'h0003, newop OP_MUL, ans=16'h0005 -> V1_reg=16'h0005, op_reg=OP_MUL, V2_reg=0, state OPSEL.
- Repeat eq and flow-mode overwrite: in RESULT with V2=16'h0003, eq -> calc_req=1 with V2_reg still 16'h0003. Later in RESULT, key 7 -> V1_reg=16'h0007, state ENTER1.
- Simultaneous pulses and keys while busy: newhex+newop+eq in the same cycle in ENTER2 -> eq wins, state BUSY. newhex during BUSY -> V1_reg/V2_reg unchanged.
- Reset mid-BUSY (CALC_BACKSPACE_EN defined, for the del check): reset low while calc_req=1 -> calc_req=0 immediately, all outputs 0. Then keys 1,2,3 followed by del -> V1_reg=16'h0012.
